// File: rtl/diff_commit_queue.sv
// diff_commit_queue: compacting commit buffer between retirement and the
// difftest commit channels; accepts holey groups, drains dense bursts.
module diff_commit_queue #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4,
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [IN_W-1:0]              in_valid,
    input  logic [IN_W*64-1:0]           in_pc,
    input  logic [IN_W*32-1:0]           in_instr,
    input  logic [IN_W-1:0]              in_skip,
    input  logic [IN_W-1:0]              in_wen,
    input  logic [IN_W*8-1:0]            in_wdest,
    input  logic [IN_W*64-1:0]           in_wdata,
    output logic                         in_ready,
    input  logic                         drain_en,
    output logic [OUT_W-1:0]             out_valid,
    output logic [OUT_W*64-1:0]          out_pc,
    output logic [OUT_W*32-1:0]          out_instr,
    output logic [OUT_W-1:0]             out_skip,
    output logic [OUT_W-1:0]             out_wen,
    output logic [OUT_W*8-1:0]           out_wdest,
    output logic [OUT_W*64-1:0]          out_wdata,
    output logic [OUT_W*8-1:0]           out_index,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [63:0]                  commit_cnt
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);

    typedef struct packed {
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTRW-1:0]   r_head;
    logic [PTRW-1:0]   r_tail;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [63:0]       r_commit_cnt;

    entry_t            w_in  [IN_W];
    logic [PTRW-1:0]   w_off [IN_W];
    logic [PTRW-1:0]   w_n_in;
    logic [PTRW-1:0]   w_n_acc;
    logic [PTRW-1:0]   w_n_out;
    logic              w_any;
    logic              w_accept;
    logic              w_drop;

    assign in_ready   = (CW'(DEPTH) - r_count) >= CW'(IN_W);
    assign w_any      = |in_valid;
    assign w_accept   = in_ready && w_any;
    assign w_drop     = !in_ready && w_any;
    assign w_n_acc    = w_accept ? w_n_in : '0;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign commit_cnt = r_commit_cnt;

    // Unpack slots and give each valid slot its compacted offset from tail
    always_comb begin
        w_n_in = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_in[i].skip  = in_skip[i];
            w_in[i].wen   = in_wen[i];
            w_in[i].wdest = in_wdest[i*8 +: 8];
            w_in[i].wdata = in_wdata[i*64 +: 64];
            w_in[i].instr = in_instr[i*32 +: 32];
            w_in[i].pc    = in_pc[i*64 +: 64];
            w_off[i]      = w_n_in;
            if (in_valid[i]) begin
                w_n_in = w_n_in + PTRW'(1);
            end
        end
    end

    // Drain amount: up to OUT_W of the registered occupancy, none in step mode
    always_comb begin
        w_n_out = '0;
        if (drain_en) begin
            if (r_count < CW'(OUT_W)) begin
                w_n_out = PTRW'(r_count);
            end else begin
                w_n_out = PTRW'(OUT_W);
            end
        end
    end

    // Present head entries on the low channels; idle channels read as zero
    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_instr = '0;
        out_skip  = '0;
        out_wen   = '0;
        out_wdest = '0;
        out_wdata = '0;
        out_index = '0;
        for (int k = 0; k < OUT_W; k++) begin
            out_index[k*8 +: 8] = 8'(k);
            if (PTRW'(k) < w_n_out) begin
                out_valid[k]         = 1'b1;
                out_pc[k*64 +: 64]   = r_mem[r_head + PTRW'(k)].pc;
                out_instr[k*32 +: 32] = r_mem[r_head + PTRW'(k)].instr;
                out_skip[k]          = r_mem[r_head + PTRW'(k)].skip;
                out_wen[k]           = r_mem[r_head + PTRW'(k)].wen;
                out_wdest[k*8 +: 8]  = r_mem[r_head + PTRW'(k)].wdest;
                out_wdata[k*64 +: 64] = r_mem[r_head + PTRW'(k)].wdata;
            end
        end
    end

    // Write accepted slots into consecutive entries starting at tail
    always_ff @(posedge clock) begin
        if (w_accept && !reset) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in_valid[i]) begin
                    r_mem[r_tail + w_off[i]] <= w_in[i];
                end
            end
        end
    end

    // Pointers, occupancy, sticky overflow and retired counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_commit_cnt <= '0;
        end else begin
            r_tail       <= r_tail + w_n_acc;
            r_head       <= r_head + w_n_out;
            r_count      <= r_count + CW'(w_n_acc) - CW'(w_n_out);
            r_commit_cnt <= r_commit_cnt + 64'(w_n_out);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_diff_commit_queue.sv
// tb_diff_commit_queue: directed checks of diff_commit_queue with a
// 4-wide drain instance and a 2-wide drain instance on shared inputs.
module tb_diff_commit_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         drain_en = 1'b1;
    logic [3:0]   in_valid = '0;
    logic [255:0] in_pc = '0;
    logic [127:0] in_instr = '0;
    logic [3:0]   in_skip = '0;
    logic [3:0]   in_wen = '0;
    logic [31:0]  in_wdest = '0;
    logic [255:0] in_wdata = '0;

    logic         rdy1, ovf1;
    logic [3:0]   ov1, o1_skip, o1_wen;
    logic [255:0] o1_pc, o1_wdata;
    logic [127:0] o1_instr;
    logic [31:0]  o1_wdest, o1_idx;
    logic [4:0]   cnt1;
    logic [63:0]  cc1;

    logic         rdy2, ovf2;
    logic [1:0]   ov2, o2_skip, o2_wen;
    logic [127:0] o2_pc, o2_wdata;
    logic [63:0]  o2_instr;
    logic [15:0]  o2_wdest, o2_idx;
    logic [4:0]   cnt2;
    logic [63:0]  cc2;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_pc;

    always #5 clk = ~clk;

    diff_commit_queue #(.IN_W(4), .OUT_W(4), .DEPTH(16)) u_dut (
        .clock(clk), .reset(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_skip(in_skip), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_ready(rdy1), .drain_en(drain_en),
        .out_valid(ov1), .out_pc(o1_pc), .out_instr(o1_instr),
        .out_skip(o1_skip), .out_wen(o1_wen), .out_wdest(o1_wdest),
        .out_wdata(o1_wdata), .out_index(o1_idx), .count(cnt1),
        .overflow(ovf1), .commit_cnt(cc1)
    );

    diff_commit_queue #(.IN_W(4), .OUT_W(2), .DEPTH(16)) u_dut2 (
        .clock(clk), .reset(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_skip(in_skip), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_ready(rdy2), .drain_en(drain_en),
        .out_valid(ov2), .out_pc(o2_pc), .out_instr(o2_instr),
        .out_skip(o2_skip), .out_wen(o2_wen), .out_wdest(o2_wdest),
        .out_wdata(o2_wdata), .out_index(o2_idx), .count(cnt2),
        .overflow(ovf2), .commit_cnt(cc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [63:0] base);
        in_valid = v;
        for (int i = 0; i < 4; i++) begin
            in_pc[i*64 +: 64]    = base + 64'(4 * i);
            in_instr[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            in_wdata[i*64 +: 64] = 64'hD000_0000_0000_0000 + base + 64'(i);
            in_wdest[i*8 +: 8]   = 8'(i + 1);
            in_wen[i]            = 1'b1;
            in_skip[i]           = (i == 3);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drain_en = 1'b1;
        do_reset();
        #1;
        n_cmp++; if (cnt1 !== 5'd0) begin
            $display("FAIL rst_count got %0d want 0", cnt1); n_err++; end
        n_cmp++; if (rdy1 !== 1'b1) begin
            $display("FAIL rst_ready got %b want 1", rdy1); n_err++; end
        n_cmp++; if (ov1 !== 4'b0) begin
            $display("FAIL rst_valid got %b want 0", ov1); n_err++; end
        n_cmp++; if (ovf1 !== 1'b0 || cc1 !== 64'd0) begin
            $display("FAIL rst_ovf_cc got %b/%0d want 0/0", ovf1, cc1); n_err++; end
        n_cmp++; if (o1_pc !== '0 || o1_wdata !== '0) begin
            $display("FAIL rst_payload got %h want 0", o1_pc); n_err++; end
    endtask

    task automatic test_holes();
        drive(4'b1011, 64'h1c00_0000);
        tick();
        in_valid = '0;
        #1;
        n_cmp++; if (ov1 !== 4'b0111) begin
            $display("FAIL holes_valid got %b want 0111", ov1); n_err++; end
        n_cmp++; if (o1_pc[63:0] !== 64'h1c00_0000) begin
            $display("FAIL holes_pc0 got %h want 1c000000", o1_pc[63:0]); n_err++; end
        n_cmp++; if (o1_pc[127:64] !== 64'h1c00_0004) begin
            $display("FAIL holes_pc1 got %h want 1c000004", o1_pc[127:64]); n_err++; end
        n_cmp++; if (o1_pc[191:128] !== 64'h1c00_000c) begin
            $display("FAIL holes_pc2 got %h want 1c00000c", o1_pc[191:128]); n_err++; end
        n_cmp++; if (o1_pc[255:192] !== 64'h0 || o1_skip[3] !== 1'b0) begin
            $display("FAIL holes_ch3 got %h want 0", o1_pc[255:192]); n_err++; end
        n_cmp++; if (o1_instr[95:64] !== 32'hA000_0003 || o1_wdest[23:16] !== 8'd4) begin
            $display("FAIL holes_ch2_instr got %h/%0d want a0000003/4",
                     o1_instr[95:64], o1_wdest[23:16]); n_err++; end
        n_cmp++; if (o1_wdata[191:128] !== 64'hD000_0000_1C00_0003 || o1_skip !== 4'b0100) begin
            $display("FAIL holes_ch2_data got %h/%b want d00000001c000003/0100",
                     o1_wdata[191:128], o1_skip); n_err++; end
        n_cmp++; if (o1_idx !== 32'h0302_0100) begin
            $display("FAIL holes_index got %h want 03020100", o1_idx); n_err++; end
        n_cmp++; if (cnt1 !== 5'd3) begin
            $display("FAIL holes_cnt_mid got %0d want 3", cnt1); n_err++; end
        tick();
        n_cmp++; if (cnt1 !== 5'd0 || cc1 !== 64'd3) begin
            $display("FAIL holes_after got %0d/%0d want 0/3", cnt1, cc1); n_err++; end
    endtask

    task automatic test_backpressure();
        do_reset();
        drain_en = 1'b0;
        for (int g = 0; g < 5; g++) begin
            drive(4'hF, 64'h8000_0000 + 64'(16 * g));
            #1;
            n_cmp++; if (rdy1 !== (g < 4)) begin
                $display("FAIL bp_ready_%0d got %b want %b", g, rdy1, (g < 4)); n_err++; end
            tick();
        end
        in_valid = '0;
        #1;
        n_cmp++; if (cnt1 !== 5'd16 || ovf1 !== 1'b1) begin
            $display("FAIL bp_full got %0d/%b want 16/1", cnt1, ovf1); n_err++; end
        n_cmp++; if (ov1 !== 4'b0 || rdy1 !== 1'b0) begin
            $display("FAIL bp_hold got %b/%b want 0000/0", ov1, rdy1); n_err++; end
        drain_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (ov1 !== 4'hF || o1_pc[63:0] !== 64'h8000_0000 + 64'(16 * c)
                         || o1_pc[255:192] !== 64'h8000_000c + 64'(16 * c)) begin
                $display("FAIL bp_drain_%0d got %b %h %h", c, ov1,
                         o1_pc[63:0], o1_pc[255:192]); n_err++; end
            tick();
        end
        n_cmp++; if (cnt1 !== 5'd0 || cc1 !== 64'd16 || ovf1 !== 1'b1) begin
            $display("FAIL bp_end got %0d/%0d/%b want 0/16/1", cnt1, cc1, ovf1); n_err++; end
    endtask

    task automatic test_reset_mid();
        drain_en = 1'b0;
        drive(4'hF, 64'h9000_0000); tick();
        drive(4'hF, 64'h9000_0010); tick();
        drive(4'b0001, 64'h9000_0020); tick();
        in_valid = '0;
        #1;
        n_cmp++; if (cnt1 !== 5'd9) begin
            $display("FAIL rmid_pre got %0d want 9", cnt1); n_err++; end
        rst = 1'b1;
        drain_en = 1'b1;
        drive(4'hF, 64'h9100_0000);
        tick();
        rst = 1'b0;
        in_valid = '0;
        #1;
        n_cmp++; if (cnt1 !== 5'd0 || ov1 !== 4'b0 || rdy1 !== 1'b1) begin
            $display("FAIL rmid_state got %0d/%b/%b want 0/0000/1", cnt1, ov1, rdy1); n_err++; end
        n_cmp++; if (ovf1 !== 1'b0 || cc1 !== 64'd0) begin
            $display("FAIL rmid_flags got %b/%0d want 0/0", ovf1, cc1); n_err++; end
        tick();
        n_cmp++; if (cnt1 !== 5'd0 || cc1 !== 64'd0) begin
            $display("FAIL rmid_noenq got %0d/%0d want 0/0", cnt1, cc1); n_err++; end
    endtask

    task automatic test_narrow_wrap();
        do_reset();
        drain_en = 1'b1;
        exp_pc = 64'h4000_0000;
        for (int g = 0; g < 6; g++) begin
            drive(4'hF, 64'h4000_0000 + 64'(16 * g));
            #1;
            n_cmp++; if (rdy2 !== 1'b1 || cnt2 !== ((g == 0) ? 5'd0 : 5'(2 * g + 2))) begin
                $display("FAIL nw_cnt_%0d got %0d/%b", g, cnt2, rdy2); n_err++; end
            if (g > 0) begin
                n_cmp++; if (ov2 !== 2'b11 || o2_pc[63:0] !== exp_pc
                             || o2_pc[127:64] !== exp_pc + 64'd4) begin
                    $display("FAIL nw_order_%0d got %h %h want %h", g,
                             o2_pc[63:0], o2_pc[127:64], exp_pc); n_err++; end
                exp_pc = exp_pc + 64'd8;
            end
            tick();
        end
        in_valid = '0;
        #1;
        n_cmp++; if (cnt2 !== 5'd14 || rdy2 !== 1'b0) begin
            $display("FAIL nw_stall got %0d/%b want 14/0", cnt2, rdy2); n_err++; end
        for (int c = 0; c < 7; c++) begin
            #1;
            n_cmp++; if (ov2 !== 2'b11 || o2_pc[63:0] !== exp_pc
                         || o2_pc[127:64] !== exp_pc + 64'd4) begin
                $display("FAIL nw_drain_%0d got %h %h want %h", c,
                         o2_pc[63:0], o2_pc[127:64], exp_pc); n_err++; end
            exp_pc = exp_pc + 64'd8;
            tick();
        end
        n_cmp++; if (cnt2 !== 5'd0 || cc2 !== 64'd24 || ovf2 !== 1'b0) begin
            $display("FAIL nw_end got %0d/%0d/%b want 0/24/0", cnt2, cc2, ovf2); n_err++; end
        n_cmp++; if (o2_idx !== 16'h0100) begin
            $display("FAIL nw_index got %h want 0100", o2_idx); n_err++; end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drain_en = 1'b0;
        drive(4'hF, 64'h2000_0000); tick();
        drive(4'b0001, 64'h2000_0010); tick();
        in_valid = '0;
        #1;
        n_cmp++; if (cnt2 !== 5'd5 || ov2 !== 2'b00) begin
            $display("FAIL sc_pre got %0d/%b want 5/00", cnt2, ov2); n_err++; end
        drain_en = 1'b1;
        drive(4'b1110, 64'h3000_0000);
        #1;
        n_cmp++; if (ov2 !== 2'b11 || o2_pc !== {64'h2000_0004, 64'h2000_0000}) begin
            $display("FAIL sc_head0 got %b %h", ov2, o2_pc); n_err++; end
        tick();
        in_valid = '0;
        #1;
        n_cmp++; if (cnt2 !== 5'd6 || o2_pc !== {64'h2000_000c, 64'h2000_0008}) begin
            $display("FAIL sc_next got %0d %h want 6", cnt2, o2_pc); n_err++; end
        tick();
        n_cmp++; if (o2_pc !== {64'h3000_0004, 64'h2000_0010}) begin
            $display("FAIL sc_mix got %h", o2_pc); n_err++; end
        tick();
        n_cmp++; if (o2_pc !== {64'h3000_000c, 64'h3000_0008}) begin
            $display("FAIL sc_tail got %h", o2_pc); n_err++; end
        tick();
        n_cmp++; if (cnt2 !== 5'd0 || cc2 !== 64'd8 || cnt1 !== 5'd0 || cc1 !== 64'd8) begin
            $display("FAIL sc_end got %0d/%0d %0d/%0d want 0/8 0/8",
                     cnt2, cc2, cnt1, cc1); n_err++; end
    endtask

    task automatic test_idle();
        drain_en = 1'b1;
        drive(4'b0000, 64'hFFFF_FFFF_FFFF_FFF0);
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (cnt1 !== 5'd0 || cc1 !== 64'd8 || cc2 !== 64'd8 || ov1 !== 4'b0
                         || o1_pc !== '0 || o1_wdata !== '0 || o1_instr !== '0) begin
                $display("FAIL idle_%0d got cnt %0d cc %0d/%0d valid %b", c,
                         cnt1, cc1, cc2, ov1); n_err++; end
        end
    endtask

    initial begin
        test_reset();
        test_holes();
        test_backpressure();
        test_reset_mid();
        test_narrow_wrap();
        test_same_cycle();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/diff_commit_queue.md
# diff_commit_queue

Parametrised commit buffer between the core's retirement stage and the difftest commit sinks. It accepts up to IN_W retiring instructions per cycle with arbitrary holes in the valid mask, compacts them in program order into a circular queue, and drains up to OUT_W entries per cycle onto densely packed difftest commit channels. It also provides backpressure, a sticky overflow flag, a drain-enable mode for single-step debugging and a 64-bit retired-instruction counter. Each output channel k feeds one DifftestInstrCommit instance with index k.

## Interface
- IN_W, 4: retirement slots per cycle (1..8); slot 0 is oldest.
- OUT_W, 4: difftest commit channels (1..8).
- DEPTH, 16: queue entries; power of two, DEPTH >= IN_W + OUT_W.
- Entry payload per slot: skip(1), wen(1), wdest(8), wdata(64), instr(32), pc(64) = 170 bits. Buses are flattened with slot i at bits [i*W +: W].
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  IN_W  per-slot retire valid; holes allowed.
- in_pc / in_instr / in_skip / in_wen / in_wdest / in_wdata  in  IN_W×{64,32,1,1,8,64}  per-slot payload.
- in_ready  out  1  queue can absorb a full IN_W group this cycle.
- drain_en  in  1  1 = drain normally, 0 = hold queue contents (step mode).
- out_valid  out  OUT_W  packed low: bit k set only if bits 0..k-1 are set.
- out_pc / out_instr / out_skip / out_wen / out_wdest / out_wdata  out  OUT_W×{…}  head entries, oldest on channel 0.
- out_index  out  OUT_W×8  constant k on channel k.
- count  out  clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a non-empty input group was dropped.
- commit_cnt  out  64  total entries drained since reset.

## Operation
- Storage is a DEPTH-entry array with head and tail pointers of log2(DEPTH) bits. Pointers wrap modulo DEPTH. count is held explicitly, so full and empty are unambiguous.
- in_ready = (DEPTH − count) >= IN_W. It is computed from registered count only and has no combinational path from in_valid or drain_en.
- Accept condition is in_ready && |in_valid. Under accept, n_in = popcount(in_valid).
  - Valid slots are written in ascending slot order to tail, tail+1, … tail+n_in−1 (mod DEPTH).
  - Invalid slots are skipped, so there are no holes in the queue.
- Drop condition is !in_ready && |in_valid. The whole group is discarded (never partially accepted), overflow is set to 1, and overflow clears only on reset.
- Drain: n_out = drain_en ? min(count, OUT_W) : 0.
  - out_valid[k] = (k < n_out).
  - Channel k shows the entry at head+k (mod DEPTH).
  - At the edge, head advances by n_out.
  - Channels with out_valid[k] = 0 drive all payload fields to 0.
- Simultaneous accept and drain in one cycle: count_next = count + n_in − n_out. An entry being enqueued is never drained in the same cycle.
- commit_cnt adds n_out each cycle and wraps at 2^64.
- Holding drain_en low freezes head and outputs all-zero valid. Enqueue continues until in_ready falls.

## Timing
- Reset (synchronous, evaluated at the rising edge) sets:
  - head = tail = count = 0, overflow = 0, commit_cnt = 0.
  - The outputs are therefore out_valid = 0, in_ready = 1 and all payload outputs 0.
  - Array contents are don't-care.
- Reset asserted mid-operation discards all queued entries at that edge. Input presented in the reset cycle is not accepted.
- Latency: an entry accepted at edge t is visible on the outputs in the cycle after t at the earliest, i.e. 1 cycle when the queue was empty and drain_en = 1.
- Outputs are a combinational read of registered array, head and count, stable for the whole cycle.
- Throughput is min(IN_W, OUT_W) per cycle sustained. When IN_W > OUT_W, bursts are absorbed up to DEPTH.
- in_ready deasserts in the cycle after count exceeds DEPTH − IN_W. The core must stall retirement while it is low; dropped groups are flagged, never silently merged.

## Test plan
- Reset, then in_valid = 4'b1011 with pc 0x1c000000/04/08/0c (slots 0,1,3) → next cycle out_valid = 4'b0111, out_pc = 0x1c000000, 0x1c000004, 0x1c00000c; out_index = 0,1,2; count returns to 0; commit_cnt = 3.
- drain_en = 0, five full groups of 4 (DEPTH = 16) → in_ready falls after count = 16 (it was 1 at count = 12); 5th group dropped; overflow = 1; count = 16; out_valid = 0. Raise drain_en → 4 entries per cycle in pc order; count reaches 0 after 4 cycles; commit_cnt = 16; overflow stays 1.
- IN_W = 4, OUT_W = 2, continuous full groups with drain on → count grows by 2 per cycle; in_ready drops at count = 14; output order is strictly sequential across the pointer wrap (tail 15→0).
- Same-cycle enqueue 3 and drain 2 at count = 5 → count = 6 next cycle; head advances 2 and tail advances 3 modulo 16.
- Reset asserted with count = 9 and a valid input group → next cycle count = 0, out_valid = 0, in_ready = 1, overflow = 0, commit_cnt = 0; the input group is not enqueued.
- in_valid = 0 for 10 cycles → no state change; commit_cnt constant; out payload all zero.
